// File: rtl/busca_pkg.sv
// Shared definitions for the linear-search sequencer that drives a 7485 comparator:
// state codes, cascade constants and operand width.
package busca_pkg;

  localparam int LARGURA = 4;

  localparam logic [LARGURA-1:0] VALOR_MAX = 4'hF;

  // Cascade inputs that make a single 7485 report A==B on its igual output
  localparam logic CASC_MAIOR = 1'b0;
  localparam logic CASC_MENOR = 1'b0;
  localparam logic CASC_IGUAL = 1'b1;

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    COMPARA   = 4'd2,
    ACHOU     = 4'd3,
    NAO_ACHOU = 4'd4,
    ERRO      = 4'd5
  } estado_t;

  function automatic logic um_quente(input logic a, input logic b, input logic c);
    return (a ^ b ^ c) & ~(a & b & c);
  endfunction

endpackage

// File: rtl/contador_4bits_ce.sv
// 4-bit up counter with synchronous clear, count enable and terminal-count flag.
// Holds the operand presented to the comparator's A inputs.
module contador_4bits_ce
  import busca_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               limpa,
  input  logic               conta,
  output logic [LARGURA-1:0] valor,
  output logic               fim
);

  logic [LARGURA-1:0] valor_q;
  logic [LARGURA-1:0] valor_d;

  always_comb begin
    valor_d = valor_q;
    if (limpa) begin
      valor_d = '0;
    end else if (conta) begin
      valor_d = valor_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign valor = valor_q;
  assign fim   = (valor_q == VALOR_MAX);

endmodule

// File: rtl/busca_sequencial_7485.sv
// Linear search 0..15 for the comparator's B value: presents A, waits ESPERA_CICLOS
// settle cycles, samples maior/menor/igual once, and reports found/position/error.
module busca_sequencial_7485
  import busca_pkg::*;
#(
  parameter int unsigned ESPERA_CICLOS = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               iniciar,
  input  logic               A_maior_que_B,
  input  logic               A_menor_que_B,
  input  logic               A_igual_a_B,
  output logic [LARGURA-1:0] valor_A,
  output logic               cascata_maior,
  output logic               cascata_menor,
  output logic               cascata_igual,
  output logic               pronto,
  output logic               encontrado,
  output logic [LARGURA-1:0] posicao,
  output logic               erro,
  output logic [3:0]         db_estado
);

  localparam logic [3:0] RECARGA = 4'(ESPERA_CICLOS - 1);

  estado_t            estado_q, estado_d;
  logic [3:0]         espera_q, espera_d;
  logic [LARGURA-1:0] posicao_q, posicao_d;
  logic               pronto_q, pronto_d;
  logic               encontrado_q, encontrado_d;
  logic               erro_q, erro_d;

  logic               limpa;
  logic               conta;
  logic               fim;
  logic [LARGURA-1:0] valor;

  contador_4bits_ce u_contador (
    .clock   (clock),
    .reset_n (reset_n),
    .limpa   (limpa),
    .conta   (conta),
    .valor   (valor),
    .fim     (fim)
  );

  always_comb begin
    estado_d     = estado_q;
    espera_d     = espera_q;
    posicao_d    = posicao_q;
    pronto_d     = pronto_q;
    encontrado_d = encontrado_q;
    erro_d       = erro_q;
    limpa        = 1'b0;
    conta        = 1'b0;

    case (estado_q)
      INICIAL, ACHOU, NAO_ACHOU, ERRO: begin
        // A restart from a terminal state wipes the previous result on the same edge
        if (iniciar) begin
          estado_d     = PREPARA;
          espera_d     = RECARGA;
          limpa        = 1'b1;
          posicao_d    = '0;
          pronto_d     = 1'b0;
          encontrado_d = 1'b0;
          erro_d       = 1'b0;
        end
      end

      PREPARA: begin
        if (espera_q == 4'd0) begin
          estado_d = COMPARA;
        end else begin
          espera_d = espera_q - 4'd1;
        end
      end

      COMPARA: begin
        if (!um_quente(A_maior_que_B, A_menor_que_B, A_igual_a_B)) begin
          estado_d = ERRO;
          pronto_d = 1'b1;
          erro_d   = 1'b1;
        end else if (A_igual_a_B) begin
          estado_d     = ACHOU;
          posicao_d    = valor;
          pronto_d     = 1'b1;
          encontrado_d = 1'b1;
        end else if (A_maior_que_B || fim) begin
          // B is below the scan point, or the scan ran out at 15 without wrapping
          estado_d = NAO_ACHOU;
          pronto_d = 1'b1;
        end else begin
          estado_d = PREPARA;
          espera_d = RECARGA;
          conta    = 1'b1;
        end
      end

      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= INICIAL;
      espera_q     <= 4'd0;
      posicao_q    <= '0;
      pronto_q     <= 1'b0;
      encontrado_q <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      espera_q     <= espera_d;
      posicao_q    <= posicao_d;
      pronto_q     <= pronto_d;
      encontrado_q <= encontrado_d;
      erro_q       <= erro_d;
    end
  end

  assign valor_A       = valor;
  assign cascata_maior = CASC_MAIOR;
  assign cascata_menor = CASC_MENOR;
  assign cascata_igual = CASC_IGUAL;
  assign pronto        = pronto_q;
  assign encontrado    = encontrado_q;
  assign posicao       = posicao_q;
  assign erro          = erro_q;
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_busca_sequencial_7485.sv
// Bench for busca_sequencial_7485: behavioural 7485 comparators in the loop, directed
// searches, expected results queued at start and checked when pronto rises.
module tb_busca_sequencial_7485;

  localparam int W = 22;  // {latency[7:0], valor_A, db_estado, posicao, encontrado, erro}

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  logic reset_n;

  // Instance with ESPERA_CICLOS=1
  logic       iniciar1;
  logic [3:0] b1;
  logic       ovr1;
  logic       maior1, menor1, igual1;
  logic [3:0] valor_a1, posicao1, db1;
  logic       cm1, cn1, ci1, pronto1, enc1, erro1;

  // Instance with ESPERA_CICLOS=3
  logic       iniciar3;
  logic [3:0] b3;
  logic       maior3, menor3, igual3;
  logic [3:0] valor_a3, posicao3, db3;
  logic       cm3, cn3, ci3, pronto3, enc3, erro3;

  function automatic logic [2:0] cmp7485(input logic [3:0] a, input logic [3:0] b,
                                         input logic gt_in, input logic lt_in,
                                         input logic eq_in);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return {gt_in, lt_in, eq_in};
  endfunction

  // Override forces maior=1, menor=1 for one COMPARA cycle
  assign {maior1, menor1, igual1} = ovr1 ? 3'b110 : cmp7485(valor_a1, b1, cm1, cn1, ci1);
  assign {maior3, menor3, igual3} = cmp7485(valor_a3, b3, cm3, cn3, ci3);

  busca_sequencial_7485 #(.ESPERA_CICLOS(1)) dut1 (
    .clock         (clock),
    .reset_n       (reset_n),
    .iniciar       (iniciar1),
    .A_maior_que_B (maior1),
    .A_menor_que_B (menor1),
    .A_igual_a_B   (igual1),
    .valor_A       (valor_a1),
    .cascata_maior (cm1),
    .cascata_menor (cn1),
    .cascata_igual (ci1),
    .pronto        (pronto1),
    .encontrado    (enc1),
    .posicao       (posicao1),
    .erro          (erro1),
    .db_estado     (db1)
  );

  busca_sequencial_7485 #(.ESPERA_CICLOS(3)) dut3 (
    .clock         (clock),
    .reset_n       (reset_n),
    .iniciar       (iniciar3),
    .A_maior_que_B (maior3),
    .A_menor_que_B (menor3),
    .A_igual_a_B   (igual3),
    .valor_A       (valor_a3),
    .cascata_maior (cm3),
    .cascata_menor (cn3),
    .cascata_igual (ci3),
    .pronto        (pronto3),
    .encontrado    (enc3),
    .posicao       (posicao3),
    .erro          (erro3),
    .db_estado     (db3)
  );

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp3_q[$];
  int start1 = 0;
  int start3 = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] pack(input int lat, input logic [3:0] va,
                                        input logic [3:0] db, input logic [3:0] pos,
                                        input logic enc, input logic err);
    return {lat[7:0], va, db, pos, enc, err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_result(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lat=%0d va=%0d db=%0d pos=%0d enc=%0b err=%0b, expected lat=%0d va=%0d db=%0d pos=%0d enc=%0b err=%0b",
               name, act[21:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
               exp[21:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Monitors: pop one expectation on each rising edge of pronto
  task automatic monitor1();
    logic prev = 1'b0;
    forever begin
      @(negedge clock);
      if (pronto1 && !prev) begin
        if (exp1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1_unexpected_pronto: got pronto=1 expected no result");
        end else begin
          compare_result("dut1_result",
                         pack(edge_cnt - start1 - 1, valor_a1, db1, posicao1, enc1, erro1),
                         exp1_q.pop_front());
        end
      end
      prev = pronto1;
    end
  endtask

  task automatic monitor3();
    logic prev = 1'b0;
    forever begin
      @(negedge clock);
      if (pronto3 && !prev) begin
        if (exp3_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut3_unexpected_pronto: got pronto=1 expected no result");
        end else begin
          compare_result("dut3_result",
                         pack(edge_cnt - start3 - 1, valor_a3, db3, posicao3, enc3, erro3),
                         exp3_q.pop_front());
        end
      end
      prev = pronto3;
    end
  endtask

  // Drivers: iniciar high for exactly one rising edge; returns at the following negedge
  task automatic go1(input logic [3:0] b, input bit push, input logic [W-1:0] exp);
    @(negedge clock);
    b1       = b;
    iniciar1 = 1'b1;
    start1   = edge_cnt;
    if (push) exp1_q.push_back(exp);
    @(negedge clock);
    iniciar1 = 1'b0;
  endtask

  task automatic go3(input logic [3:0] b, input logic [W-1:0] exp);
    @(negedge clock);
    b3       = b;
    iniciar3 = 1'b1;
    start3   = edge_cnt;
    exp3_q.push_back(exp);
    @(negedge clock);
    iniciar3 = 1'b0;
  endtask

  task automatic drain1(input string name);
    int n = 0;
    while (exp1_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp1_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pronto expected pronto within 200 cycles", name);
      exp1_q.delete();
    end
  endtask

  task automatic drain3(input string name);
    int n = 0;
    while (exp3_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp3_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pronto expected pronto within 200 cycles", name);
      exp3_q.delete();
    end
  endtask

  task automatic wait_point1(input string name, input logic [3:0] va, input bit need_cmp);
    int n = 0;
    while (!(valor_a1 == va && (!need_cmp || db1 == 4'd2)) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got valor_A=%0d expected %0d", name, valor_a1, va);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    iniciar1 = 1'b0;
    iniciar3 = 1'b0;
    b1       = 4'd0;
    b3       = 4'd0;
    ovr1     = 1'b0;

    #12;
    check("rst_pronto", {31'd0, pronto1}, 32'd0);
    check("rst_encontrado", {31'd0, enc1}, 32'd0);
    check("rst_erro", {31'd0, erro1}, 32'd0);
    check("rst_posicao", {28'd0, posicao1}, 32'd0);
    check("rst_valor_A", {28'd0, valor_a1}, 32'd0);
    check("rst_db_estado", {28'd0, db1}, 32'd0);
    check("cascata", {29'd0, cm1, cn1, ci1}, 32'd1);

    @(negedge clock);
    reset_n = 1'b1;

    fork
      monitor1();
      monitor3();
    join_none

    // B=5 found after 6 scanned values of 2 cycles each
    go1(4'd5, 1'b1, pack(12, 4'd5, 4'd3, 4'd5, 1'b1, 1'b0));
    drain1("b5");

    // Restart from ACHOU: result cleared on the sampling edge
    go1(4'd2, 1'b1, pack(6, 4'd2, 4'd3, 4'd2, 1'b1, 1'b0));
    check("restart_encontrado", {31'd0, enc1}, 32'd0);
    check("restart_pronto", {31'd0, pronto1}, 32'd0);
    check("restart_posicao", {28'd0, posicao1}, 32'd0);
    drain1("b2");

    go1(4'd0, 1'b1, pack(2, 4'd0, 4'd3, 4'd0, 1'b1, 1'b0));
    drain1("b0");

    go1(4'd15, 1'b1, pack(32, 4'd15, 4'd3, 4'd15, 1'b1, 1'b0));
    drain1("b15");

    // B moves from 9 to 2 while A=4: A>B at the next compare
    go1(4'd9, 1'b1, pack(10, 4'd4, 4'd4, 4'd0, 1'b0, 1'b0));
    wait_point1("b_move", 4'd4, 1'b0);
    b1 = 4'd2;
    drain1("b_move");

    // Non-one-hot comparator outputs on the compare of A=2
    go1(4'd7, 1'b1, pack(6, 4'd2, 4'd5, 4'd0, 1'b0, 1'b1));
    wait_point1("ovr", 4'd2, 1'b1);
    ovr1 = 1'b1;
    @(negedge clock);
    ovr1 = 1'b0;
    drain1("ovr");

    // Reset mid-search at A=3
    go1(4'd9, 1'b0, '0);
    wait_point1("mid_reset", 4'd3, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valor_A", {28'd0, valor_a1}, 32'd0);
    check("mid_rst_db_estado", {28'd0, db1}, 32'd0);
    check("mid_rst_outputs", {29'd0, pronto1, enc1, erro1}, 32'd0);
    check("mid_rst_posicao", {28'd0, posicao1}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    go1(4'd3, 1'b1, pack(8, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0));
    drain1("after_reset");

    // Longer settle time: 4 cycles per scanned value
    go3(4'd2, pack(12, 4'd2, 4'd3, 4'd2, 1'b1, 1'b0));
    drain3("e3_b2");
    go3(4'd0, pack(4, 4'd0, 4'd3, 4'd0, 1'b1, 1'b0));
    drain3("e3_b0");

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
